// File: rtl/rv32i_clint_pkg.sv
// rv32i_clint_pkg -- shared definitions for the core-local interruptor.
//   * register offsets inside the 64 KB CLINT window
//   * reg_sel_e: decoded register select
//   * decode_offset(): window offset -> register select
//   * merge_bytes(): byte-enable merge used by every writable register
package rv32i_clint_pkg;

  localparam logic [15:0] OFF_MSIP        = 16'h0000;
  localparam logic [15:0] OFF_MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] OFF_MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] OFF_MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] OFF_MTIME_HI    = 16'hBFFC;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_CMP_LO,
    SEL_CMP_HI,
    SEL_TIME_LO,
    SEL_TIME_HI
  } reg_sel_e;

  function automatic reg_sel_e decode_offset(input logic [15:0] off);
    case (off)
      OFF_MSIP:        return SEL_MSIP;
      OFF_MTIMECMP_LO: return SEL_CMP_LO;
      OFF_MTIMECMP_HI: return SEL_CMP_HI;
      OFF_MTIME_LO:    return SEL_TIME_LO;
      OFF_MTIME_HI:    return SEL_TIME_HI;
      default:         return SEL_NONE;
    endcase
  endfunction

  // Bytes with their enable set take the new value, the rest keep the old one.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = mask[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/rv32i_clint_timebase.sv
// rv32i_clint_timebase -- 1 us time base: prescaler plus 64-bit mtime counter.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load_i            load strobe; wins over a tick in the same cycle
//   load_val_i[63:0]  value loaded into the counter (prescaler clears)
//   mtime_o[63:0]     live counter value
module rv32i_clint_timebase #(
  parameter int CLK_FREQ_MHZ = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [63:0] load_val_i,
  output logic [63:0] mtime_o
);

  localparam int PW = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ_MHZ - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [63:0]   mtime_q, mtime_d;
  logic          tick;

  assign tick = (presc_q == PRESC_MAX);

  always_comb begin
    presc_d = presc_q + 1'b1;
    mtime_d = mtime_q;
    if (load_i) begin
      presc_d = '0;
      mtime_d = load_val_i;
    end else if (tick) begin
      presc_d = '0;
      mtime_d = mtime_q + 64'd1;  // wraps silently from all-ones to 0
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      mtime_q <= '0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
    end
  end

  assign mtime_o = mtime_q;

endmodule

// File: rtl/rv32i_clint.sv
// rv32i_clint -- core-local interruptor for an RV32I core data bus.
// Bus protocol: there is no backpressure. Every cycle addr is sampled; when
// wr_en is high the cycle is a store of wdata under wr_mask, otherwise a read.
// The response (rdata, hit) is registered and appears the following cycle;
// a read in the same cycle as a write returns the pre-write value.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   addr, wdata, wr_mask, wr_en store/read request from the core
//   rdata, hit                  registered read data and window-hit flag
//   software_interrupt          msip bit 0
//   mtime_wr, mtime_din         one-cycle commit pulse + committed mtime
//   mtimecmp_wr, mtimecmp_din   one-cycle commit pulse + committed mtimecmp
// 64-bit registers are written lo first (staged) then hi (commit). The new
// hi word merges into the currently committed hi word.
module rv32i_clint
  import rv32i_clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0200_0000,
  parameter int          CLK_FREQ_MHZ = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wr_mask,
  input  logic        wr_en,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        software_interrupt,
  output logic        mtime_wr,
  output logic        mtimecmp_wr,
  output logic [63:0] mtime_din,
  output logic [63:0] mtimecmp_din
);

  logic        in_window;
  reg_sel_e    sel;
  logic [63:0] mtime_live;
  logic [63:0] time_commit;
  logic        time_load;
  logic [31:0] msip_word;

  logic        msip_q,       msip_d;
  logic [31:0] cmp_stage_q,  cmp_stage_d;
  logic [63:0] cmp_q,        cmp_d;
  logic [31:0] time_stage_q, time_stage_d;
  logic [63:0] time_din_q,   time_din_d;
  logic [31:0] snap_q,       snap_d;
  logic [31:0] rdata_q,      rdata_d;
  logic        hit_q;
  logic        cmp_wr_q,     cmp_wr_d;
  logic        time_wr_q,    time_wr_d;

  assign in_window = (addr[31:16] == BASE_ADDR[31:16]);
  assign sel       = in_window ? decode_offset(addr[15:0]) : SEL_NONE;

  // msip only holds bit 0; the merged word is reduced through a bit-0 mask.
  assign msip_word   = merge_bytes({31'b0, msip_q}, wdata, wr_mask);
  assign time_commit = {merge_bytes(time_din_q[63:32], wdata, wr_mask), time_stage_q};
  assign time_load   = wr_en && (sel == SEL_TIME_HI);

  rv32i_clint_timebase #(
    .CLK_FREQ_MHZ(CLK_FREQ_MHZ)
  ) u_timebase (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (time_load),
    .load_val_i(time_commit),
    .mtime_o   (mtime_live)
  );

  // Read mux works off current register values, so a simultaneous write
  // is not visible until the next access.
  always_comb begin
    rdata_d = '0;
    case (sel)
      SEL_MSIP:    rdata_d = {31'b0, msip_q};
      SEL_CMP_LO:  rdata_d = cmp_q[31:0];
      SEL_CMP_HI:  rdata_d = cmp_q[63:32];
      SEL_TIME_LO: rdata_d = mtime_live[31:0];
      SEL_TIME_HI: rdata_d = snap_q;
      default:     rdata_d = '0;
    endcase
  end

  always_comb begin
    msip_d       = msip_q;
    cmp_stage_d  = cmp_stage_q;
    cmp_d        = cmp_q;
    time_stage_d = time_stage_q;
    time_din_d   = time_din_q;
    snap_d       = snap_q;
    cmp_wr_d     = 1'b0;
    time_wr_d    = 1'b0;
    if (wr_en) begin
      case (sel)
        SEL_MSIP:    msip_d = |(msip_word & 32'h1);
        SEL_CMP_LO:  cmp_stage_d = merge_bytes(cmp_stage_q, wdata, wr_mask);
        SEL_CMP_HI: begin
          cmp_d    = {merge_bytes(cmp_q[63:32], wdata, wr_mask), cmp_stage_q};
          cmp_wr_d = 1'b1;
        end
        SEL_TIME_LO: time_stage_d = merge_bytes(time_stage_q, wdata, wr_mask);
        SEL_TIME_HI: begin
          time_din_d = time_commit;
          time_wr_d  = 1'b1;
        end
        default: ;
      endcase
    end else if (sel == SEL_TIME_LO) begin
      // Reading the low half freezes the high half for a tear-free pair.
      snap_d = mtime_live[63:32];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msip_q       <= 1'b0;
      cmp_stage_q  <= '1;
      cmp_q        <= '1;
      time_stage_q <= '0;
      time_din_q   <= '0;
      snap_q       <= '0;
      rdata_q      <= '0;
      hit_q        <= 1'b0;
      cmp_wr_q     <= 1'b0;
      time_wr_q    <= 1'b0;
    end else begin
      msip_q       <= msip_d;
      cmp_stage_q  <= cmp_stage_d;
      cmp_q        <= cmp_d;
      time_stage_q <= time_stage_d;
      time_din_q   <= time_din_d;
      snap_q       <= snap_d;
      rdata_q      <= rdata_d;
      hit_q        <= in_window;
      cmp_wr_q     <= cmp_wr_d;
      time_wr_q    <= time_wr_d;
    end
  end

  assign rdata              = rdata_q;
  assign hit                = hit_q;
  assign software_interrupt = msip_q;
  assign mtime_wr           = time_wr_q;
  assign mtimecmp_wr        = cmp_wr_q;
  assign mtime_din          = time_din_q;
  assign mtimecmp_din       = cmp_q;

endmodule

// File: tb/tb_rv32i_clint.sv
module tb_rv32i_clint;

  localparam int          CLK_F = 4;
  localparam logic [31:0] BASE  = 32'h0200_0000;
  localparam logic [31:0] A_MSIP   = BASE + 32'h0000;
  localparam logic [31:0] A_CMP_LO = BASE + 32'h4000;
  localparam logic [31:0] A_CMP_HI = BASE + 32'h4004;
  localparam logic [31:0] A_TM_LO  = BASE + 32'hBFF8;
  localparam logic [31:0] A_TM_HI  = BASE + 32'hBFFC;
  localparam logic [31:0] A_OUT    = 32'h0300_0000;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wr_mask = '0;
  logic        wr_en = 1'b0;
  logic [31:0] rdata;
  logic        hit;
  logic        software_interrupt;
  logic        mtime_wr;
  logic        mtimecmp_wr;
  logic [63:0] mtime_din;
  logic [63:0] mtimecmp_din;

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  rv32i_clint #(
    .BASE_ADDR   (BASE),
    .CLK_FREQ_MHZ(CLK_F)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .addr              (addr),
    .wdata             (wdata),
    .wr_mask           (wr_mask),
    .wr_en             (wr_en),
    .rdata             (rdata),
    .hit               (hit),
    .software_interrupt(software_interrupt),
    .mtime_wr          (mtime_wr),
    .mtimecmp_wr       (mtimecmp_wr),
    .mtime_din         (mtime_din),
    .mtimecmp_din      (mtimecmp_din)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mtime is described as "value at last load plus whole microseconds
  // elapsed since that load", counted in clock edges.
  logic        ref_msip;
  logic [31:0] ref_cmp_stage, ref_time_stage, ref_snap;
  logic [63:0] ref_cmp, ref_time_din, ref_base;
  int          ref_load;

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] m);
    logic [31:0] en;
    en = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    return (o & ~en) | (n & en);
  endfunction

  task automatic model_reset();
    ref_msip       = 1'b0;
    ref_cmp_stage  = 32'hFFFF_FFFF;
    ref_cmp        = 64'hFFFF_FFFF_FFFF_FFFF;
    ref_time_stage = '0;
    ref_time_din   = '0;
    ref_snap       = '0;
    ref_base       = '0;
    ref_load       = edge_cnt;
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge; drives one bus cycle, checks the registered
  // response just after the rising edge, returns at the next falling edge.
  task automatic step(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] m, input logic w);
    int          e;
    logic        in_win;
    logic [15:0] off;
    logic [63:0] live;
    logic [31:0] exp_rd;
    logic        exp_twr, exp_cwr;
    addr = a; wdata = d; wr_mask = m; wr_en = w;
    @(posedge clk);
    #1;
    e      = edge_cnt;
    live   = ref_base + 64'((e - 1 - ref_load) / CLK_F);
    in_win = (a[31:16] == BASE[31:16]);
    off    = a[15:0];
    exp_rd = '0;
    if (in_win) begin
      case (off)
        16'h0000: exp_rd = {31'b0, ref_msip};
        16'h4000: exp_rd = ref_cmp[31:0];
        16'h4004: exp_rd = ref_cmp[63:32];
        16'hBFF8: exp_rd = live[31:0];
        16'hBFFC: exp_rd = ref_snap;
        default:  exp_rd = '0;
      endcase
    end
    exp_twr = 1'b0;
    exp_cwr = 1'b0;
    if (in_win && w) begin
      case (off)
        16'h0000: if (m[0]) ref_msip = d[0];
        16'h4000: ref_cmp_stage = bmerge(ref_cmp_stage, d, m);
        16'h4004: begin
          ref_cmp = {bmerge(ref_cmp[63:32], d, m), ref_cmp_stage};
          exp_cwr = 1'b1;
        end
        16'hBFF8: ref_time_stage = bmerge(ref_time_stage, d, m);
        16'hBFFC: begin
          ref_time_din = {bmerge(ref_time_din[63:32], d, m), ref_time_stage};
          ref_base     = ref_time_din;
          ref_load     = e;
          exp_twr      = 1'b1;
        end
        default: ;
      endcase
    end else if (in_win && off == 16'hBFF8) begin
      ref_snap = live[63:32];
    end
    check("rdata", 64'(rdata), 64'(exp_rd));
    check("hit", 64'(hit), 64'(in_win));
    check("software_interrupt", 64'(software_interrupt), 64'(ref_msip));
    check("mtime_wr", 64'(mtime_wr), 64'(exp_twr));
    check("mtimecmp_wr", 64'(mtimecmp_wr), 64'(exp_cwr));
    check("mtime_din", mtime_din, ref_time_din);
    check("mtimecmp_din", mtimecmp_din, ref_cmp);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    addr = A_MSIP; wdata = 32'h1; wr_mask = 4'hF; wr_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst rdata", 64'(rdata), 64'h0);
    check("rst hit", 64'(hit), 64'h0);
    check("rst sw_irq", 64'(software_interrupt), 64'h0);
    check("rst mtime_wr", 64'(mtime_wr), 64'h0);
    check("rst mtimecmp_wr", 64'(mtimecmp_wr), 64'h0);
    check("rst mtime_din", mtime_din, 64'h0);
    check("rst mtimecmp_din", mtimecmp_din, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    rst_n = 1'b1;
    addr = '0; wr_en = 1'b0;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    logic        w;
    logic [31:0] exp_rd;
    logic        exp_hit;
    logic        exp_sw;
    logic        exp_cwr;
    logic [63:0] exp_cdin;
  } vec_t;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  vec_t vecs[16];

  initial begin
    logic [31:0] d;
    logic [3:0]  m;
    int          op;

    vecs[0]  = '{A_MSIP,   32'h1,         4'hF, 1'b1, 32'h0,         1'b1, 1'b1, 1'b0, ONES};
    vecs[1]  = '{A_MSIP,   32'h0,         4'h0, 1'b0, 32'h1,         1'b1, 1'b1, 1'b0, ONES};
    vecs[2]  = '{A_MSIP,   32'hFFFF_FFFE, 4'hF, 1'b1, 32'h1,         1'b1, 1'b0, 1'b0, ONES};
    vecs[3]  = '{A_MSIP,   32'h1,         4'hE, 1'b1, 32'h0,         1'b1, 1'b0, 1'b0, ONES};
    vecs[4]  = '{A_CMP_LO, 32'h0,         4'h0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, ONES};
    vecs[5]  = '{A_CMP_LO, 32'h1000,      4'hF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, ONES};
    vecs[6]  = '{A_CMP_LO, 32'h0,         4'h0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, ONES};
    vecs[7]  = '{A_CMP_HI, 32'h0,         4'h0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, ONES};
    vecs[8]  = '{A_CMP_HI, 32'h0,         4'hF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 64'h1000};
    vecs[9]  = '{A_CMP_LO, 32'h0,         4'h0, 1'b0, 32'h1000,      1'b1, 1'b0, 1'b0, 64'h1000};
    vecs[10] = '{A_CMP_HI, 32'h0,         4'h0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 64'h1000};
    vecs[11] = '{A_OUT,    32'h1,         4'hF, 1'b1, 32'h0,         1'b0, 1'b0, 1'b0, 64'h1000};
    vecs[12] = '{A_MSIP,   32'h0,         4'h0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 64'h1000};
    vecs[13] = '{BASE + 32'h1234, 32'h0,  4'h0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 64'h1000};
    vecs[14] = '{BASE + 32'h1234, 32'h5,  4'hF, 1'b1, 32'h0,         1'b1, 1'b0, 1'b0, 64'h1000};
    vecs[15] = '{32'h0300_4000, 32'h0,    4'h0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 64'h1000};

    model_reset();
    do_reset();

    // 8 clocks at 4 cycles/us after reset -> mtime = 2
    idle(8);
    step(A_TM_LO, 32'h0, 4'h0, 1'b0);
    check("mtime after 8 clk", 64'(rdata), 64'h2);

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].a, vecs[i].d, vecs[i].m, vecs[i].w);
      check($sformatf("vec%0d rdata", i), 64'(rdata), 64'(vecs[i].exp_rd));
      check($sformatf("vec%0d hit", i), 64'(hit), 64'(vecs[i].exp_hit));
      check($sformatf("vec%0d sw_irq", i), 64'(software_interrupt), 64'(vecs[i].exp_sw));
      check($sformatf("vec%0d mtimecmp_wr", i), 64'(mtimecmp_wr), 64'(vecs[i].exp_cwr));
      check($sformatf("vec%0d mtimecmp_din", i), mtimecmp_din, vecs[i].exp_cdin);
    end

    // Masked hi commit merges into the committed hi word.
    do_reset();
    step(A_TM_LO, 32'h5, 4'hF, 1'b1);
    check("lo only no pulse", 64'(mtime_wr), 64'h0);
    step(A_TM_HI, 32'hFFFF_FFAB, 4'b0001, 1'b1);
    check("masked hi pulse", 64'(mtime_wr), 64'h1);
    check("masked hi din", mtime_din, 64'h0000_00AB_0000_0005);
    idle(1);
    check("pulse one cycle", 64'(mtime_wr), 64'h0);
    check("din held", mtime_din, 64'h0000_00AB_0000_0005);

    // Carry from low to high half with a tear-free snapshot pair.
    step(A_TM_LO, 32'hFFFF_FFFF, 4'hF, 1'b1);
    step(A_TM_HI, 32'h0, 4'hF, 1'b1);
    step(A_TM_LO, 32'h0, 4'h0, 1'b0);
    check("pre-carry lo", 64'(rdata), 64'hFFFF_FFFF);
    idle(3);
    step(A_TM_HI, 32'h0, 4'h0, 1'b0);
    check("pre-carry hi snapshot", 64'(rdata), 64'h0);
    step(A_TM_LO, 32'h0, 4'h0, 1'b0);
    check("post-carry lo", 64'(rdata), 64'h0);
    step(A_TM_HI, 32'h0, 4'h0, 1'b0);
    check("post-carry hi", 64'(rdata), 64'h1);

    // Reset between lo and hi discards the staged lo.
    step(A_CMP_LO, 32'h1234, 4'hF, 1'b1);
    do_reset();
    idle(2);
    step(A_CMP_HI, 32'h0, 4'hF, 1'b1);
    check("reset drops staged lo", mtimecmp_din, 64'h0000_0000_FFFF_FFFF);
    check("post-reset commit pulse", 64'(mtimecmp_wr), 64'h1);

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      if (i == 250) do_reset();
      op = $urandom_range(0, 11);
      d  = $urandom;
      m  = 4'($urandom_range(0, 15));
      case (op)
        0: step(A_MSIP, d, m, 1'b1);
        1: step(A_CMP_LO, d, m, 1'b1);
        2: step(A_CMP_HI, d, m, 1'b1);
        3: step(A_TM_LO, ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : d,
                m, 1'b1);
        4: step(A_TM_HI, d, m, 1'b1);
        5: step(A_MSIP, d, m, 1'b0);
        6: step(A_CMP_LO, d, m, 1'b0);
        7: step(A_CMP_HI, d, m, 1'b0);
        8: step(A_TM_LO, d, m, 1'b0);
        9: step(A_TM_HI, d, m, 1'b0);
        10: step(BASE + 32'($urandom_range(1, 16'h3FFF)), d, m, ($urandom_range(0, 1) != 0));
        default: step(A_OUT + (d & 32'h0000_FFFC), d, m, ($urandom_range(0, 1) != 0));
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rv32i_clint.md
RV32I_CLINT -- requirements
Module: rv32i_clint

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0200_0000; the 64 KB decode window is addr[31:16]==BASE_ADDR[31:16].
REQ-002 SHALL have parameter CLK_FREQ_MHZ, default 100; it sets clock cycles per mtime tick (1 us).
REQ-003 SHALL have one clock and an asynchronous active-low reset, ports clk and rst_n.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 addr  input  32  data bus address from core (daddr).
REQ-007 wdata  input  32  store data from core (dout, mask-aligned).
REQ-008 wr_mask  input  4  byte enables {b3,b2,b1,b0}.
REQ-009 wr_en  input  1  store strobe, single cycle per store.
REQ-010 rdata  output  32  registered read data, valid one cycle after addr.
REQ-011 hit  output  1  registered: previous-cycle addr fell in window (read-mux select for core din).
REQ-012 software_interrupt  output  1  msip bit 0.
REQ-013 mtime_wr / mtimecmp_wr  output  1 each  one-cycle commit pulses to core CSR.
REQ-014 mtime_din / mtimecmp_din  output  64 each  committed 64-bit values, stable while the pulse is high and until the next commit.

Function
REQ-015 Register map at offset addr[15:0]: 0x0000 msip (bit 0 only, others read 0); 0x4000 mtimecmp_lo; 0x4004 mtimecmp_hi; 0xBFF8 mtime_lo; 0xBFFC mtime_hi; other window offsets read 0 and ignore writes.
REQ-016 Writes SHALL apply only to bytes with wr_mask set; unmasked bytes keep their old value.
REQ-017 Write to *_lo SHALL update a staging register only; no commit pulse.
REQ-018 Write to *_hi SHALL commit {merged hi, staged lo} to the shadow register and *_din, with *_wr high exactly the cycle after the write.
REQ-019 Local mtime counter: prescaler counts 0..CLK_FREQ_MHZ-1; at the terminal count mtime increments by 1 and the prescaler returns to 0; 64-bit wrap from all-ones to 0, no flag.
REQ-020 On mtime commit, counter loads the committed value and prescaler clears; commit wins over a simultaneous tick.
REQ-021 Read of mtime_lo SHALL return live low half and snapshot live high half; the next read of mtime_hi returns that snapshot (tear-free pair).
REQ-022 Read of mtime_hi without a prior lo read SHALL return the snapshot value (reset 0).
REQ-023 Read of mtimecmp halves SHALL return the committed shadow, not staging.
REQ-024 Simultaneous read and write (same cycle) SHALL return the pre-write value.
REQ-025 wr_en with addr outside the window SHALL have no effect; rdata SHALL be 0 and hit 0 next cycle.
REQ-026 software_interrupt SHALL equal msip bit 0, updated the cycle after the write.

Reset
REQ-027 On rst_n low: msip=0, mtime counter=0, prescaler=0, snapshot=0, mtime staging=0.
REQ-028 mtimecmp shadow, staging and mtimecmp_din SHALL reset to all-ones; mtime_din=0.
REQ-029 rdata=0, hit=0, mtime_wr=0, mtimecmp_wr=0 during and after reset until a qualifying access.
REQ-030 A reset asserted between lo and hi writes SHALL discard the staged lo; no pulse after release.

Structure
REQ-031 Register offsets (0x0000, 0x4000, 0x4004, 0xBFF8, 0xBFFC) SHALL be localparams in the shared rv32i package.
REQ-032 Byte-masked merge SHALL be one function used for all writable registers.
REQ-033 Prescaler plus 64-bit counter SHALL be one sub-module, rv32i_clint_timebase.
REQ-034 No combinational path from addr/wr_en to any output.

Verification
REQ-035 Write 0x1 to 0x0000 (mask 4'hF) -> software_interrupt=1 next cycle; read 0x0000 -> rdata=1.
REQ-036 Write mtimecmp_lo=0x0000_1000, then mtimecmp_hi=0x0 -> single mtimecmp_wr pulse, mtimecmp_din=64'h0000_0000_0000_1000; only lo write -> no pulse, readback still all-ones.
REQ-037 CLK_FREQ_MHZ=4: after reset, 8 clocks -> mtime_lo read returns 2.
REQ-038 Commit mtime=64'h0000_0000_FFFF_FFFF, then wait 1 tick -> read lo=0, hi=1; pair stays consistent across the carry.
REQ-039 Write mtime_hi with mask 4'b0001 data 0xAB, staged lo 0x5 -> mtime_din=64'h0000_00AB_0000_0005.
REQ-040 Assert rst_n low after mtimecmp_lo write, release, write mtimecmp_hi=0 -> mtimecmp_din=64'h0000_0000_FFFF_FFFF.
